// File: rtl/bcd_frame_counter_pkg.sv
// Shared display constants and BCD helpers for the frame counter and
// downstream digit decoder/bitmap stages.
package bcd_frame_counter_pkg;

  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned COUNT_W    = DIGIT_W * NUM_DIGITS;
  localparam int unsigned SEL_W      = 2;
  localparam int unsigned PRESC_W    = 8;
  localparam int unsigned PEND_W     = 2;
  localparam int unsigned OUTST_W    = 3;

  typedef logic [DIGIT_W-1:0] bcd_t;

  localparam bcd_t              BCD_MAX  = 4'd9;
  localparam logic [PEND_W-1:0] PEND_MAX = 2'd3;

  // Next BCD value; anything at or above 9 folds back to 0.
  function automatic bcd_t bcd_next(input bcd_t d);
    return (d >= BCD_MAX) ? '0 : bcd_t'(d + 4'd1);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One registered BCD digit of the ripple-carry counter chain.
module bcd_digit
  import bcd_frame_counter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_carry_in,
  output bcd_t o_digit,
  output logic o_carry_out_c
);

  bcd_t r_digit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_digit <= '0;
    end else if (i_clear) begin
      r_digit <= '0;
    end else if (i_carry_in) begin
      r_digit <= bcd_next(r_digit);
    end
  end

  assign o_digit       = r_digit;
  assign o_carry_out_c = i_carry_in && (r_digit == BCD_MAX);

endmodule

// File: rtl/bcd_frame_counter.sv
// Four-digit BCD counter advanced by a vsync prescaler and external requests,
// with a per-frame display latch and a registered rollover pulse.
module bcd_frame_counter
  import bcd_frame_counter_pkg::*;
#(
  parameter int unsigned PRESCALE = 60
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             vsync,
  input  logic             enable,
  input  logic             clear,
  input  logic             inc,
  input  logic [SEL_W-1:0] digit_sel,
  output bcd_t             digit,
  output logic             wrap
);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALE - 32'd1);

  logic                r_vsync_q;
  logic                r_armed;
  logic [PRESC_W-1:0]  r_presc;
  logic [PEND_W-1:0]   r_pending;
  logic [COUNT_W-1:0]  r_display;
  logic                r_wrap;

  logic                w_frame_tick;
  logic                w_presc_last;
  logic                w_sec_tick;
  logic                w_do_inc;
  logic [OUTST_W-1:0]  w_outstanding;
  logic [PEND_W-1:0]   w_pend_next;
  logic [NUM_DIGITS:0] w_carry;
  logic [COUNT_W-1:0]  w_count;

  // r_armed blocks a tick until vsync has been seen low after reset.
  assign w_frame_tick  = vsync & ~r_vsync_q & r_armed;
  assign w_presc_last  = (r_presc == PRESC_LAST);
  assign w_sec_tick    = w_frame_tick & enable & w_presc_last;
  assign w_outstanding = OUTST_W'(r_pending) + OUTST_W'(w_sec_tick) + OUTST_W'(inc);
  assign w_do_inc      = ~clear & (w_outstanding != '0);

  // One increment per cycle; the excess is carried forward, saturating at 3.
  always_comb begin
    w_pend_next = '0;
    if (w_outstanding > OUTST_W'(PEND_MAX)) begin
      w_pend_next = PEND_MAX;
    end else if (w_outstanding != '0) begin
      w_pend_next = PEND_W'(w_outstanding - OUTST_W'(1));
    end
  end

  assign w_carry[0] = w_do_inc;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk           (clk),
      .reset         (reset),
      .i_clear       (clear),
      .i_carry_in    (w_carry[g]),
      .o_digit       (w_count[g*DIGIT_W +: DIGIT_W]),
      .o_carry_out_c (w_carry[g+1])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vsync_q <= 1'b0;
      r_armed   <= 1'b0;
      r_presc   <= '0;
      r_pending <= '0;
      r_display <= '0;
      r_wrap    <= 1'b0;
    end else begin
      r_vsync_q <= vsync;
      r_armed   <= r_armed | ~vsync;
      if (clear) begin
        r_presc   <= '0;
        r_pending <= '0;
        r_display <= '0;
        r_wrap    <= 1'b0;
      end else begin
        if (w_frame_tick && enable) begin
          r_presc <= w_presc_last ? '0 : PRESC_W'(r_presc + 8'd1);
        end
        r_pending <= w_pend_next;
        // Display takes the pre-increment count so a frame shows one stable value.
        if (w_frame_tick) begin
          r_display <= w_count;
        end
        r_wrap <= w_carry[NUM_DIGITS];
      end
    end
  end

  always_comb begin
    digit = '0;
    case (digit_sel)
      2'd0:    digit = r_display[0*DIGIT_W +: DIGIT_W];
      2'd1:    digit = r_display[1*DIGIT_W +: DIGIT_W];
      2'd2:    digit = r_display[2*DIGIT_W +: DIGIT_W];
      default: digit = r_display[3*DIGIT_W +: DIGIT_W];
    endcase
  end

  assign wrap = r_wrap;

endmodule

// File: tb/tb_bcd_frame_counter.sv
// Scoreboard bench for bcd_frame_counter (PRESCALE = 2): stimulus queues
// expected values, a monitor pops and compares them against the DUT.
module tb_bcd_frame_counter;

  logic       clk       = 1'b0;
  logic       reset     = 1'b0;
  logic       vsync     = 1'b0;
  logic       enable    = 1'b0;
  logic       clear     = 1'b0;
  logic       inc       = 1'b0;
  logic [1:0] digit_sel = 2'd0;
  logic [3:0] digit;
  logic       wrap;

  always #5 clk = ~clk;

  bcd_frame_counter #(.PRESCALE(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .vsync     (vsync),
    .enable    (enable),
    .clear     (clear),
    .inc       (inc),
    .digit_sel (digit_sel),
    .digit     (digit),
    .wrap      (wrap)
  );

  wire [15:0] a_count   = dut.w_count;
  wire [15:0] a_display = dut.r_display;
  wire [7:0]  a_presc   = dut.r_presc;
  wire [1:0]  a_pending = dut.r_pending;

  typedef enum int {K_DIGIT, K_COUNT, K_DISP, K_WRAP, K_PRESC, K_PEND} kind_e;
  typedef struct {
    kind_e       kind;
    logic [15:0] val;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic string kname(input kind_e k);
    case (k)
      K_DIGIT: return "digit";
      K_COUNT: return "count";
      K_DISP:  return "display";
      K_WRAP:  return "wrap";
      K_PRESC: return "prescaler";
      default: return "pending";
    endcase
  endfunction

  function automatic logic [15:0] actual(input kind_e k);
    case (k)
      K_DIGIT: return {12'd0, digit};
      K_COUNT: return a_count;
      K_DISP:  return a_display;
      K_WRAP:  return {15'd0, wrap};
      K_PRESC: return {8'd0, a_presc};
      default: return {14'd0, a_pending};
    endcase
  endfunction

  function automatic bit digits_ok(input logic [31:0] v);
    for (int i = 0; i < 8; i++) begin
      if (v[i*4 +: 4] > 4'd9) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Monitor: samples 1 ns after each falling clock edge or reset assertion.
  always begin : monitor
    exp_t        e;
    logic [15:0] a;
    @(negedge clk or negedge reset);
    #1;
    checks++;
    if (!digits_ok({a_count, a_display})) begin
      errors++;
      $display("FAIL digit_range: count=%h display=%h, every nibble must be <= 9", a_count, a_display);
    end
    while (q.size() > 0) begin
      e = q.pop_front();
      a = actual(e.kind);
      checks++;
      if (a !== e.val) begin
        errors++;
        $display("FAIL %s: got %h, expected %h (t=%0t)", kname(e.kind), a, e.val, $time);
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input kind_e k, input logic [15:0] v);
    exp_t e;
    e.kind = k;
    e.val  = v;
    q.push_back(e);
  endtask

  task automatic expect_digit(input logic [1:0] sel, input logic [3:0] v);
    digit_sel = sel;
    expect_v(K_DIGIT, {12'd0, v});
  endtask

  task automatic drain();
    @(negedge clk);
    #2;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked", q.size());
      q.delete();
    end
  endtask

  task automatic pulse();
    vsync = 1'b1;
    step();
    vsync = 1'b0;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held: everything zero; vsync high across release must not tick.
    vsync  = 1'b1;
    enable = 1'b1;
    expect_v(K_COUNT, 16'h0000);
    expect_v(K_DISP,  16'h0000);
    expect_v(K_WRAP,  16'h0000);
    expect_v(K_PRESC, 16'h0000);
    expect_v(K_PEND,  16'h0000);
    expect_digit(2'd3, 4'd0);
    drain();
    reset = 1'b1;
    step(3);
    expect_v(K_PRESC, 16'h0000);
    expect_v(K_COUNT, 16'h0000);
    drain();
    for (int i = 0; i < 4; i++) begin
      expect_digit(2'(i), 4'd0);
      drain();
    end
    vsync = 1'b0;
    step();

    // Four frame ticks at PRESCALE 2 -> two automatic increments.
    repeat (4) pulse();
    expect_v(K_COUNT, 16'h0002);
    expect_v(K_DISP,  16'h0001);
    expect_v(K_PRESC, 16'h0000);
    expect_digit(2'd0, 4'd1);
    drain();
    pulse();
    expect_v(K_COUNT, 16'h0002);
    expect_v(K_DISP,  16'h0002);
    expect_v(K_PRESC, 16'h0001);
    expect_digit(2'd0, 4'd2);
    drain();

    // inc coincident with sec_tick -> +1 now, +1 next cycle.
    vsync = 1'b1;
    inc   = 1'b1;
    step();
    vsync = 1'b0;
    inc   = 1'b0;
    expect_v(K_COUNT, 16'h0003);
    expect_v(K_PEND,  16'h0001);
    expect_v(K_PRESC, 16'h0000);
    expect_v(K_DISP,  16'h0002);
    drain();
    step();
    expect_v(K_COUNT, 16'h0004);
    expect_v(K_PEND,  16'h0000);
    drain();

    // enable low freezes the prescaler; inc still honoured.
    pulse();
    expect_v(K_PRESC, 16'h0001);
    expect_v(K_DISP,  16'h0004);
    drain();
    enable = 1'b0;
    pulse();
    pulse();
    expect_v(K_PRESC, 16'h0001);
    expect_v(K_COUNT, 16'h0004);
    drain();
    inc = 1'b1;
    step();
    inc = 1'b0;
    expect_v(K_COUNT, 16'h0005);
    drain();

    // Reach 0123, then clear with inc and a sec_tick in the same cycle.
    inc = 1'b1;
    step(118);
    inc = 1'b0;
    expect_v(K_COUNT, 16'h0123);
    expect_v(K_DISP,  16'h0004);
    drain();
    enable = 1'b1;
    vsync  = 1'b1;
    inc    = 1'b1;
    clear  = 1'b1;
    step();
    clear = 1'b0;
    inc   = 1'b0;
    vsync = 1'b0;
    expect_v(K_COUNT, 16'h0000);
    expect_v(K_DISP,  16'h0000);
    expect_v(K_PRESC, 16'h0000);
    expect_v(K_PEND,  16'h0000);
    expect_v(K_WRAP,  16'h0000);
    expect_digit(2'd1, 4'd0);
    drain();

    // Rollover: 9998 incs, then 9999, then 0000 with a one-cycle wrap.
    inc = 1'b1;
    step(9998);
    inc = 1'b0;
    expect_v(K_COUNT, 16'h9998);
    expect_v(K_WRAP,  16'h0000);
    drain();
    inc = 1'b1;
    step();
    inc = 1'b0;
    expect_v(K_COUNT, 16'h9999);
    expect_v(K_WRAP,  16'h0000);
    drain();
    inc = 1'b1;
    step();
    inc = 1'b0;
    expect_v(K_COUNT, 16'h0000);
    expect_v(K_WRAP,  16'h0001);
    drain();
    step();
    expect_v(K_COUNT, 16'h0000);
    expect_v(K_WRAP,  16'h0000);
    drain();

    // Build pending = 2, then assert reset between clock edges.
    pulse();
    expect_v(K_PRESC, 16'h0001);
    drain();
    inc = 1'b1;
    for (int i = 0; i < 5; i++) begin
      vsync = (i % 2 == 0);
      step();
    end
    inc   = 1'b0;
    vsync = 1'b0;
    expect_v(K_COUNT, 16'h0005);
    expect_v(K_PEND,  16'h0002);
    expect_v(K_DISP,  16'h0004);
    drain();
    expect_v(K_COUNT, 16'h0000);
    expect_v(K_PEND,  16'h0000);
    expect_v(K_DISP,  16'h0000);
    expect_v(K_WRAP,  16'h0000);
    expect_v(K_PRESC, 16'h0000);
    expect_digit(2'd0, 4'd0);
    reset = 1'b0;
    #2;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL reset_async: %0d expectations left unchecked", q.size());
      q.delete();
    end
    step(2);
    reset = 1'b1;
    step(4);
    expect_v(K_COUNT, 16'h0000);
    expect_v(K_PEND,  16'h0000);
    expect_v(K_WRAP,  16'h0000);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_frame_counter.md
BCD_FRAME_COUNTER -- requirements
Module: bcd_frame_counter

Interface
REQ-001 The block SHALL have parameter PRESCALE, default 60, giving the number of frame ticks per automatic increment (legal range 1..255).
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state is clocked on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, an asynchronous active-low reset.
REQ-004 The block SHALL have port vsync, input, 1, the active-high vertical sync from video_sync_generator.
REQ-005 The block SHALL have port enable, input, 1, which gates the prescaler only.
REQ-006 The block SHALL have port clear, input, 1, a synchronous clear.
REQ-007 The block SHALL have port inc, input, 1, an external single-cycle increment request, honoured regardless of enable.
REQ-008 The block SHALL have port digit_sel, input, 2, which selects a display digit: 0 = ones, 3 = thousands.
REQ-009 The block SHALL have port digit, output, 4, the selected BCD digit of the display latch (combinational from digit_sel).
REQ-010 The block SHALL have port wrap, output, 1, a one-cycle registered pulse on 9999 -> 0000 rollover.

Function
REQ-011 frame_tick SHALL be a rising-edge detect: vsync high while registered vsync_q is low.
REQ-012 The prescaler (8 bits) SHALL advance only on frame_tick with enable high; on reaching PRESCALE-1 it SHALL return to 0 and assert sec_tick in the same cycle.
REQ-013 Count SHALL be four BCD digits, and each digit SHALL stay within 0..9 at all times.
REQ-014 Each cycle SHALL apply at most one +1 to the count; outstanding = pending + sec_tick + inc.
REQ-015 If outstanding > 0, count SHALL increment and pending SHALL become min(outstanding-1, 3); otherwise pending SHALL stay 0.
REQ-016 Increment SHALL ripple the BCD carry: a digit at 9 becomes 0 and carries into the next digit; 9999 SHALL become 0000.
REQ-017 wrap SHALL be high in exactly the cycle after the 9999 -> 0000 increment takes effect, and low otherwise.
REQ-018 On frame_tick, the display latch SHALL load the count register value held before that cycle's increment.
REQ-019 The display latch SHALL be unchanged between frame ticks, so the displayed value never changes mid-frame.
REQ-020 clear SHALL have top priority: count, prescaler, pending and display latch SHALL go to 0 next cycle, wrap SHALL be 0, and inc/sec_tick in that cycle SHALL be discarded.
REQ-021 Deasserting enable SHALL freeze the prescaler value, with no reset of it; pending increments SHALL still drain.

Reset
REQ-022 While reset is low: count = 0000, display = 0000, prescaler = 0, pending = 0, vsync_q = 0, wrap = 0, and therefore digit = 0 for every digit_sel.
REQ-023 Reset asserted mid-operation SHALL take effect immediately, without waiting for a clock edge, and SHALL discard all pending increments.
REQ-024 After reset is released, the first frame_tick SHALL require vsync to be low for at least one clock.

Structure
REQ-025 The constants BCD_MAX (4'd9) and NUM_DIGITS (4) SHALL live in the shared video/display constants package used by the digit decoder and bitmap stages.
REQ-026 One sub-module, bcd_digit, SHALL be instantiated four times in a chain; each instance holds one registered digit with carry_in, clear and carry_out (carry_out = carry_in and digit == 9).
REQ-027 digit SHALL feed seven_segment_decoder directly; digit_sel is driven from hpos bits by the top level.

Verification (PRESCALE = 2 in bench)
REQ-028 Scenario: reset low, then high; sweep digit_sel 0..3 -> digit = 0 for all four.
REQ-029 Scenario: enable = 1, 4 vsync pulses -> count = 0002 after the 4th frame_tick; display shows 0001 after the 4th tick and 0002 after the 5th.
REQ-030 Scenario: inc pulse coincident with sec_tick -> count +1 in that cycle, +1 again next cycle (total +2); pending returns to 0.
REQ-031 Scenario: count preset to 9998 via 9998 inc pulses, then 2 inc pulses -> 9999, then 0000; wrap high exactly one cycle after the rollover; no digit ever reads above 9.
REQ-032 Scenario: clear asserted together with inc and frame_tick at count 0123 -> next cycle count = 0000, display = 0000, prescaler = 0, wrap = 0.
REQ-033 Scenario: reset pulsed low mid-frame with pending = 2 -> all outputs 0 immediately; after release, no residual increment occurs.
